// File: rtl/sdram_axi_burst_master.sv
// sdram_axi_burst_master: single-command AXI4 INCR burst initiator for the SDRAM controller slave port
module sdram_axi_burst_master #(
  parameter int MAX_LEN = 255
) (
  input  logic        ACLK,
  input  logic        ARSTN,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [7:0]  cmd_len,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [31:0] wr_data,
  input  logic [3:0]  wr_strb,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic [31:0] rd_data,
  output logic        rd_last,
  output logic        done,
  output logic        err,
  output logic        AXI_awvalid,
  output logic [31:0] AXI_awaddr,
  output logic [7:0]  AXI_awlen,
  output logic [1:0]  AXI_awburst,
  output logic        AXI_wvalid,
  output logic [31:0] AXI_wdata,
  output logic [3:0]  AXI_wstrb,
  output logic        AXI_wlast,
  output logic        AXI_bready,
  output logic        AXI_arvalid,
  output logic [31:0] AXI_araddr,
  output logic [7:0]  AXI_arlen,
  output logic [1:0]  AXI_arburst,
  output logic        AXI_rready,
  input  logic        AXI_awready,
  input  logic        AXI_wready,
  input  logic        AXI_bvalid,
  input  logic [1:0]  AXI_bresp,
  input  logic        AXI_arready,
  input  logic        AXI_rvalid,
  input  logic [31:0] AXI_rdata,
  input  logic [1:0]  AXI_rresp,
  input  logic        AXI_rlast
);
  typedef enum logic [2:0] {IDLE, AW, W, B, AR, R, DONE} state_t;
  state_t state, state_n;
  logic [31:0] addr_q;
  logic [7:0] len_q, cnt;
  logic err_q, accept, reject, last, w_hs, r_hs;
  assign accept = cmd_valid && cmd_ready;
  assign last = cnt == len_q;
  assign w_hs = state == W && wr_valid && AXI_wready;
  assign r_hs = state == R && AXI_rvalid && rd_ready;
  // 13-bit sum so a burst ending exactly on the 4 KB boundary is still legal
  assign reject = (cmd_addr[1:0] != 2'b00) || (32'(cmd_len) > MAX_LEN) ||
                  ({1'b0, cmd_addr[11:0]} + {3'b000, cmd_len, 2'b00} + 13'd4 > 13'd4096);
  always_ff @(posedge ACLK)
    state <= !ARSTN ? IDLE : state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (accept) state_n = reject ? DONE : cmd_write ? AW : AR;
      AW: if (AXI_awready) state_n = W;
      W: if (w_hs && last) state_n = B;
      B: if (AXI_bvalid) state_n = DONE;
      AR: if (AXI_arready) state_n = R;
      R: if (r_hs && last) state_n = DONE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge ACLK) begin
    if (!ARSTN) begin
      addr_q <= '0;
      len_q <= '0;
      cnt <= '0;
      err_q <= 1'b0;
    end else if (accept) begin
      addr_q <= cmd_addr;
      len_q <= cmd_len;
      cnt <= '0;
      err_q <= reject;
    end else begin
      if (w_hs || r_hs) cnt <= cnt + 8'd1;
      if (state == B && AXI_bvalid && AXI_bresp != 2'b00) err_q <= 1'b1;
      if (r_hs && (AXI_rresp != 2'b00 || AXI_rlast != last)) err_q <= 1'b1;
    end
  end
  always_comb begin
    cmd_ready = ARSTN && state == IDLE;
    AXI_awvalid = state == AW;
    AXI_awaddr = addr_q;
    AXI_awlen = len_q;
    AXI_awburst = 2'b01;
    AXI_arvalid = state == AR;
    AXI_araddr = addr_q;
    AXI_arlen = len_q;
    AXI_arburst = 2'b01;
    AXI_wvalid = state == W && wr_valid;
    wr_ready = state == W && AXI_wready;
    AXI_wdata = wr_data;
    AXI_wstrb = wr_strb;
    AXI_wlast = state == W && last;
    AXI_bready = state == B;
    rd_valid = state == R && AXI_rvalid;
    AXI_rready = state == R && rd_ready;
    rd_data = AXI_rdata;
    rd_last = state == R && last;
    done = state == DONE;
    err = state == DONE && err_q;
  end
endmodule
